spram512x50_cb: RTL and testbench
=================================

SPRAM512X50_CB -- requirements
Module: spram512x50_cb

Interface
REQ-001 Parameter DEPTH, default 512, number of words; SHALL equal 2**ADDR_W.
REQ-002 Parameter ADDR_W, default 9, address width in bits.
REQ-003 Parameter DATA_W, default 50, word width in bits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 Port clk, input, 1 bit: sole clock; all state changes on its rising edge except reset.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port cen, input, 1 bit: active-low chip enable; high means no access.
REQ-008 Port wen, input, 1 bit: active-low write enable; low is a write, high is a read (only when cen=0).
REQ-009 Port addr, input, ADDR_W bits: word address.
REQ-010 Port d, input, DATA_W bits: write data.
REQ-011 Port bwen, input, DATA_W bits: active-low per-bit write mask.
REQ-012 Port q, output, DATA_W bits: registered read data.
REQ-013 Port ready, output, 1 bit: high when the post-reset clear is complete and accesses are accepted.

Function
REQ-014 Storage SHALL be DEPTH words x DATA_W bits, single port, with at most one access per cycle.
REQ-015 Read: with cen=0, wen=1 and ready=1 at edge N, q SHALL equal mem[addr] after edge N (1-cycle latency).
REQ-016 Write: with cen=0, wen=0 and ready=1 at edge N, for each bit i with bwen[i]=0, mem[addr][i] SHALL take d[i]; bits with bwen[i]=1 SHALL be unchanged.
REQ-017 q SHALL hold its previous value on write cycles (no write-through).
REQ-018 q SHALL hold its previous value on idle cycles (cen=1) and on cycles where ready=0.
REQ-019 A read of an address in the cycle after it is written SHALL return the newly written data.
REQ-020 An all-ones bwen write SHALL leave memory unchanged and q unchanged.
REQ-021 All addr values 0..DEPTH-1 are valid; no wrap or out-of-range case exists.
REQ-022 The clear sequencer SHALL have two states, CLEAR and READY; it enters CLEAR on reset.
REQ-023 In CLEAR, an internal counter SHALL write all-zero to address 0,1,...,DEPTH-1, one word per cycle, starting at the first clk edge after rst_n deasserts.
REQ-024 After the write to address DEPTH-1, the sequencer SHALL move to READY and ready SHALL rise; this takes exactly DEPTH cycles (512).
REQ-025 External cen/wen/addr/d/bwen SHALL be ignored while in CLEAR.
REQ-026 Inputs are sampled only on clk rising edges; no combinational path SHALL exist from inputs to q.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force q=0, ready=0, clear counter=0 and state=CLEAR.
REQ-028 Reset asserted mid-operation (including mid-clear) SHALL abort the current activity and restart the full clear after deassertion.
REQ-029 Memory contents are undefined during reset and SHALL be all zero once ready=1.

Verification
REQ-030 Release reset and count cycles: ready=0 for 512 cycles, then 1; reads of addresses 0, 255 and 511 return 0.
REQ-031 Write 0x3_FFFF_FFFF_FFFF to address 5 with bwen=0, then read address 5: q equals 0x3_FFFF_FFFF_FFFF one cycle after the read edge; q is unchanged during the write cycle.
REQ-032 After writing all-ones to address 7, write d=0 with bwen=0x3_FFFF_FFFF_FF00 to address 7, then read: q=0x3_FFFF_FFFF_FF00.
REQ-033 Write address i with data i for i=0..511, then read them back in order: every word matches, and address 511 to address 0 has no aliasing.
REQ-034 During a read stream, hold cen=1 for 3 cycles: q holds its last value; apply wen=0 with cen=1: memory is unchanged.
REQ-035 Assert rst_n=0 at clear count 100, or after writes: q=0 at once, ready restarts its 512-cycle clear, and previously written addresses read 0.

Source files
------------

// File: rtl/spram512x50_cb.sv
// Single-port 512x50 SRAM model with per-bit write mask, registered read data and
// a post-reset clear sequencer that zeroes every word before accesses are accepted.
module spram512x50_cb #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] bwen,
  output logic [DATA_W-1:0] q,
  output logic              ready
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   q_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wmask;
  logic                rd_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Sequencer next state and the single write/read port arbitration.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = addr;
    mem_wdata = d;
    mem_wmask = ~bwen;
    rd_en     = 1'b0;

    unique case (state_q)
      S_CLEAR: begin
        // External access is ignored; the counter owns the port while clearing.
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_READY: begin
        if (!cen) begin
          if (!wen) mem_we = 1'b1;
          else      rd_en  = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_en) q_q <= mem[addr];
    end
  end

  // NOTE: the array itself has no reset; the clear sequencer zeroes it after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  assign q     = q_q;
  assign ready = (state_q == S_READY);

endmodule

// File: tb/tb_spram512x50_cb.sv
// Directed self-checking bench for spram512x50_cb: clear timing, masked writes,
// read latency, idle hold, full address sweep and reset abort/restart.
module tb_spram512x50_cb;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 50;

  localparam logic [DATA_W-1:0] ALL1  = '1;
  localparam logic [DATA_W-1:0] MASKV = 50'h3_FFFF_FFFF_FF00;

  logic              clk;
  logic              rst_n;
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] bwen;
  logic [DATA_W-1:0] q;
  logic              ready;

  int checks = 0;
  int errors = 0;

  spram512x50_cb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .wen   (wen),
    .addr  (addr),
    .d     (d),
    .bwen  (bwen),
    .q     (q),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cen  = 1'b1;
    wen  = 1'b1;
    bwen = '1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                          input logic [DATA_W-1:0] m);
    cen = 1'b0; wen = 1'b0; addr = a; d = v; bwen = m;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    cen = 1'b0; wen = 1'b1; addr = a; bwen = '1;
    tick();
    idle();
  endtask

  // Counts edges from now until ready rises; returns -1 if it never does.
  task automatic wait_clear(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (ready === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    logic [DATA_W-1:0] q_prev;

    rst_n = 1'b0;
    cen = 1'b1; wen = 1'b1; addr = '0; d = '0; bwen = '1;
    #23;
    check("reset_q", q, '0);
    check("reset_ready", {49'd0, ready}, 50'd0);

    // Release off-edge, then try to write during clear; it must be ignored.
    tick();
    rst_n = 1'b1;
    cen = 1'b0; wen = 1'b0; addr = '0; d = ALL1; bwen = '0;
    wait_clear(cyc);
    idle();
    check("clear_cycles", DATA_W'(cyc), DATA_W'(512));

    do_read(9'd0);
    check("clear_rd0", q, '0);
    do_read(9'd255);
    check("clear_rd255", q, '0);
    do_read(9'd511);
    check("clear_rd511", q, '0);

    // Full write, no write-through, then 1-cycle read latency.
    do_write(9'd5, ALL1, '0);
    check("wr_q_hold", q, '0);
    cen = 1'b0; wen = 1'b1; addr = 9'd5;
    check("rd_before_edge", q, '0);
    tick();
    idle();
    check("rd5", q, ALL1);

    // Per-bit mask: only the low 8 bits take d=0.
    do_write(9'd7, ALL1, '0);
    do_write(9'd7, '0, MASKV);
    do_read(9'd7);
    check("mask_rd7", q, MASKV);

    // All-ones bwen leaves memory and q untouched.
    do_read(9'd5);
    do_write(9'd7, '0, ALL1);
    check("nomask_q_hold", q, ALL1);
    do_read(9'd7);
    check("nomask_rd7", q, MASKV);

    // Read immediately after write returns the new data.
    do_write(9'd9, 50'h2_1234_5678_9ABC, '0);
    do_read(9'd9);
    check("raw_rd9", q, 50'h2_1234_5678_9ABC);

    // Full sweep: address i holds i.
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(i), '0);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(ADDR_W'(i));
      check($sformatf("sweep_rd%0d", i), q, DATA_W'(i));
    end

    // Idle hold during a read stream, and a write attempt with cen=1.
    do_read(9'd10);
    do_read(9'd11);
    q_prev = q;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_hold%0d", i), q, q_prev);
    end
    cen = 1'b1; wen = 1'b0; addr = 9'd10; d = ALL1; bwen = '0;
    tick();
    idle();
    check("cen_wr_q_hold", q, q_prev);
    do_read(9'd10);
    check("cen_wr_mem", q, DATA_W'(10));

    // Reset after writes: q clears at once, full clear restarts.
    do_read(9'd7);
    check("pre_rst_rd7", q, DATA_W'(7));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_q", q, '0);
    check("rst_async_ready", {49'd0, ready}, 50'd0);
    tick();
    rst_n = 1'b1;

    // Abort the clear at count 100 with another reset.
    for (int i = 0; i < 100; i++) tick();
    check("midclear_ready", {49'd0, ready}, 50'd0);
    rst_n = 1'b0;
    #1;
    check("midclear_rst_ready", {49'd0, ready}, 50'd0);
    tick();
    rst_n = 1'b1;
    wait_clear(cyc);
    check("reclear_cycles", DATA_W'(cyc), DATA_W'(512));

    do_read(9'd5);
    check("reclear_rd5", q, '0);
    do_read(9'd300);
    check("reclear_rd300", q, '0);
    do_read(9'd511);
    check("reclear_rd511", q, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
